// File: rtl/arith_pkg.sv
// Shared definitions for the serial arithmetic datapath.
//   state_t       : controller state encoding (IDLE / RUN / DONE)
//   DIGIT_DEFAULT : default slice width processed per cycle
//   calc_ndig()   : number of slices in a WIDTH-bit operand
//   calc_cnt_w()  : width of a slice counter that can hold 0..NDIG-1
//   width_ok()    : WIDTH must be a non-zero multiple of DIGIT
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DIGIT_DEFAULT = 4;

  function automatic int calc_ndig(input int width, input int digit);
    return width / digit;
  endfunction

  // A single-slice datapath still needs a 1-bit counter.
  function automatic int calc_cnt_w(input int ndig);
    return (ndig > 1) ? $clog2(ndig) : 1;
  endfunction

  function automatic bit width_ok(input int width, input int digit);
    return (digit > 0) && (width >= digit) && (width % digit == 0);
  endfunction

endpackage

// File: rtl/sub_digit.sv
// Combinational DIGIT-bit subtract cell: {bout, d} = a - b - bin.
// The borrow-out is the MSB of the DIGIT+1-bit two's-complement difference.
//   a, b : DIGIT-bit slice operands
//   bin  : borrow-in from the previous (less significant) slice
//   d    : DIGIT-bit slice difference
//   bout : borrow-out to the next slice
module sub_digit
  import arith_pkg::*;
#(
  parameter int DIGIT = DIGIT_DEFAULT
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             bin,
  output logic [DIGIT-1:0] d,
  output logic             bout
);

  logic [DIGIT:0] full;

  assign full      = {1'b0, a} - {1'b0, b} - {{DIGIT{1'b0}}, bin};
  assign {bout, d} = full;

endmodule

// File: rtl/sub_8bit_serial.sv
// Multi-cycle subtractor: diff = (a - b - bin) mod 2^WIDTH, bout = unsigned borrow.
// One DIGIT-wide slice is processed per cycle, LSB first, with the borrow
// rippled through a register. Valid/ready handshake on input and output.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid / in_ready : operand handshake (a, b, bin sampled on acceptance)
//   out_valid/out_ready : result handshake (diff, bout held while waiting)
module sub_8bit_serial
  import arith_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = DIGIT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int NDIG  = calc_ndig(WIDTH, DIGIT);
  localparam int CNT_W = calc_cnt_w(NDIG);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NDIG - 1);

  if (!width_ok(WIDTH, DIGIT)) begin : g_bad_width
    $error("sub_8bit_serial: WIDTH must be a non-zero multiple of DIGIT");
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             borrow_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] diff_q;
  logic             bout_q;

  logic [DIGIT-1:0] a_slice, b_slice, d_slice;
  logic             borrow_next;
  logic             accept;

  assign accept = (state_q == IDLE) && in_valid;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assignment first, so no path leaves state_d unassigned
    // and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)         state_d = RUN;
      RUN:     if (cnt_q == LAST)    state_d = DONE;
      DONE:    if (out_ready)        state_d = IDLE;
      default:                       state_d = IDLE;
    endcase
  end

  // Output logic.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // Select the active slice of the captured operands.
  always_comb begin
    a_slice = '0;
    b_slice = '0;
    for (int k = 0; k < NDIG; k++) begin
      if (cnt_q == CNT_W'(k)) begin
        a_slice = a_q[k*DIGIT +: DIGIT];
        b_slice = b_q[k*DIGIT +: DIGIT];
      end
    end
  end

  sub_digit #(.DIGIT(DIGIT)) u_sub_digit (
    .a    (a_slice),
    .b    (b_slice),
    .bin  (borrow_q),
    .d    (d_slice),
    .bout (borrow_next)
  );

  // Operand capture.
  // NOTE: operand registers carry no reset; they are only read in RUN, which
  // is always preceded by a capture, so resetting them would add no value.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= a;
      b_q <= b;
    end
  end

  // Slice counter, borrow ripple and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
    end else if (accept) begin
      cnt_q    <= '0;
      borrow_q <= bin;
    end else if (state_q == RUN) begin
      for (int k = 0; k < NDIG; k++) begin
        if (cnt_q == CNT_W'(k)) diff_q[k*DIGIT +: DIGIT] <= d_slice;
      end
      borrow_q <= borrow_next;
      cnt_q    <= cnt_q + 1'b1;
      if (cnt_q == LAST) bout_q <= borrow_next;
    end
  end

  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_sub_8bit_serial.sv
// Self-checking bench for sub_8bit_serial: directed corner cases plus
// randomized operations against an integer-arithmetic reference model.
module tb_sub_8bit_serial;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a, b;
  logic       bin;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] diff;
  logic       bout;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  sub_8bit_serial #(.WIDTH(8), .DIGIT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout)
  );

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    n_checks++;
    if (observed === expected) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: plain integer subtraction.
  function automatic void model(input logic [7:0] ma, input logic [7:0] mb,
                                input logic mbin, output logic [7:0] md,
                                output logic mbout);
    int r;
    r     = int'(ma) - int'(mb) - int'(mbin);
    md    = 8'(r & 255);
    mbout = (r < 0);
  endfunction

  // Run one operation; scramble inputs during RUN, stall 'stall' cycles in DONE.
  task automatic do_op(input logic [7:0] oa, input logic [7:0] ob,
                       input logic obin, input int stall, input string tag);
    logic [7:0] ed;
    logic       eb;
    int         lat;
    model(oa, ob, obin, ed, eb);
    check({tag, "/in_ready_idle"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    a = oa; b = ob; bin = obin;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
      tick();
      lat++;
    end
    check({tag, "/latency"}, 32'(lat), 32'd2);
    check({tag, "/diff"}, 32'(diff), 32'(ed));
    check({tag, "/bout"}, 32'(bout), 32'(eb));
    check({tag, "/in_ready_done"}, 32'(in_ready), 32'd0);
    for (int i = 0; i < stall; i++) begin
      a = 8'($urandom); b = 8'($urandom);
      tick();
      check({tag, "/stall_valid"}, 32'(out_valid), 32'd1);
      check({tag, "/stall_diff"}, 32'(diff), 32'(ed));
      check({tag, "/stall_bout"}, 32'(bout), 32'(eb));
      check({tag, "/stall_in_ready"}, 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "/released_valid"}, 32'(out_valid), 32'd0);
    check({tag, "/released_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "/held_diff"}, 32'(diff), 32'(ed));
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; bin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("reset/out_valid", 32'(out_valid), 32'd0);
    check("reset/in_ready", 32'(in_ready), 32'd1);
    check("reset/diff", 32'(diff), 32'd0);
    check("reset/bout", 32'(bout), 32'd0);

    do_op(8'h5A, 8'h23, 1'b0, 0, "basic");
    do_op(8'h10, 8'h01, 1'b0, 0, "slice_borrow");
    do_op(8'h00, 8'h01, 1'b0, 0, "wrap");
    do_op(8'h80, 8'h7F, 1'b1, 0, "bin_zero");
    do_op(8'h00, 8'h00, 1'b1, 0, "bin_wrap");
    do_op(8'hC3, 8'h3C, 1'b0, 5, "backpressure");

    // Reset during RUN abandons the operation.
    in_valid = 1'b1; a = 8'h77; b = 8'h11; bin = 1'b0;
    tick();
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midreset/out_valid", 32'(out_valid), 32'd0);
    check("midreset/in_ready", 32'(in_ready), 32'd1);
    check("midreset/diff", 32'(diff), 32'd0);
    check("midreset/bout", 32'(bout), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("midreset/no_result", 32'(out_valid), 32'd0);
    end
    do_op(8'h01, 8'h01, 1'b0, 0, "after_reset");

    for (int n = 0; n < 40; n++) begin
      do_op(8'($urandom), 8'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
            "random");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sub_8bit_serial.md
Name: sub_8bit_serial

Overview:
- Multi-cycle subtractor, the inverse-direction companion of the nibble-chained adder datapath: computes diff = a - b - bin.
- Processes one DIGIT-wide slice per cycle, LSB slice first, and ripples the borrow between slices through a register.
- Valid/ready handshake on both input and output so it can sit between pipelined arithmetic stages.
- Trades latency for a single DIGIT-wide subtract cell.

Parameters:
- WIDTH, 8, operand and result width in bits; must be a multiple of DIGIT.
- DIGIT, 4, slice width processed per cycle.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  operands a, b, bin are valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow-in.
- out_valid  output  1  diff/bout valid.
- out_ready  input  1  consumer accepts result.
- diff  output  WIDTH  (a - b - bin) mod 2^WIDTH.
- bout  output  1  borrow-out; 1 when a < b + bin (unsigned).

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (rst_n=0 at a rising edge):
  - state=IDLE, slice counter=0, borrow register=0, diff=0, bout=0, out_valid=0.
  - in_ready=1 from the first cycle after reset.
  - Reset mid-operation abandons the operation; no result is ever presented for it.
- FSM states: IDLE, RUN, DONE. NDIG = WIDTH/DIGIT.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid=1: capture a, b, bin into operand registers; cnt<=0; borrow<=bin; go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle: slice k=cnt computes {borrow_next, d} = a[k] - b[k] - borrow (DIGIT+1-bit two's-complement difference; borrow_next = MSB).
  - Write d into diff[k*DIGIT +: DIGIT]; borrow<=borrow_next; cnt<=cnt+1.
  - When cnt==NDIG-1: bout<=borrow_next; go to DONE.
- DONE:
  - out_valid=1, in_ready=0; diff and bout held stable.
  - On out_ready=1: go to IDLE.
  - A new operand is not accepted in the same cycle as result acceptance. Throughput is one operation per NDIG+2 cycles.
- Latency: out_valid rises exactly NDIG cycles after the acceptance edge (2 cycles at defaults).
- diff updates only during RUN. Its value between operations is the last result, and it must not glitch while out_valid=1.
- Inputs a, b, bin are don't-care outside the acceptance cycle; changing them during RUN has no effect.
- Wrap-around: the result is modulo 2^WIDTH. bout is the unsigned borrow; no signed-overflow output.
- Holding out_ready=0 stalls indefinitely in DONE with outputs constant.

Decomposition:
- Shared package (arith_pkg):
  - state enum {IDLE, RUN, DONE}.
  - DIGIT default.
  - NDIG derivation.
  - Elaboration check that WIDTH % DIGIT == 0.
- Sub-module sub_digit: combinational DIGIT-bit subtract with borrow-in and borrow-out. It mirrors the existing nibble adder cell and is instantiated once, time-multiplexed across slices.

Test Plan:
- a=0x5A, b=0x23, bin=0 -> diff=0x37, bout=0; out_valid exactly 2 cycles after acceptance.
- a=0x10, b=0x01, bin=0 -> inter-slice borrow: diff=0x0F, bout=0.
- a=0x00, b=0x01, bin=0 -> wrap: diff=0xFF, bout=1.
- a=0x80, b=0x7F, bin=1 -> diff=0x00, bout=0; then a=0x00, b=0x00, bin=1 -> diff=0xFF, bout=1.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> diff/bout constant, in_ready=0; then out_ready=1 -> IDLE next cycle, in_ready=1. Also toggle a/b during RUN -> result unaffected.
- Reset: rst_n=0 during RUN -> next cycle out_valid=0, in_ready=1, diff=0, bout=0; the following op a=0x01, b=0x01 -> diff=0x00, bout=0.
